// File: rtl/pkt_dispatch_ctrl.sv
// Packet-dispatch controller: header FIFO feeding a decode/enable-window FSM, plus an
// independent clear-channel-assessment FSM that produces the transmit grant.
module pkt_dispatch_ctrl #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EN_CYCLES  = 1,
  parameter int unsigned MAX_HOPS   = 4,
  parameter int unsigned CCA_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          newpkt,
  input  logic [2:0]                    fPacketType,
  input  logic [WORD_WIDTH-1:0]         fHopsFromCH,
  input  logic [WORD_WIDTH-1:0]         fChosenCH,
  input  logic [WORD_WIDTH-1:0]         destinationID,
  input  logic [WORD_WIDTH-1:0]         myNodeID,
  input  logic [WORD_WIDTH-1:0]         chosenCH,
  input  logic                          role,
  input  logic                          iHaveData,
  input  logic                          tx_req,
  input  logic                          tx_done,
  input  logic                          channel_clear,
  output logic                          en_KCH,
  output logic                          en_MNI,
  output logic                          en_QTU_FMB,
  output logic                          en_neighborTable,
  output logic                          en_reward,
  output logic                          iAmDestination,
  output logic                          okToSend,
  output logic                          pkt_drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [2:0]            ptype;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] ch;
    logic [WORD_WIDTH-1:0] dst;
  } hdr_t;

  typedef enum logic [1:0] {StIdle, StDecode, StEnable} disp_e;
  typedef enum logic [1:0] {TxIdle, TxCca, TxGrant} tx_e;

  // ---------------------------------------------------------------- header FIFO
  hdr_t            mem_q [FIFO_DEPTH];
  hdr_t            hdr_in;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, push, pop, drop_q;
  disp_e           disp_q, disp_d;

  assign hdr_in = {fPacketType, fHopsFromCH, fChosenCH, destinationID};
  // Full uses the pre-edge count, so a same-cycle pop never admits a push.
  assign full   = (count_q == CntW'(FIFO_DEPTH));
  assign push   = newpkt & ~full;
  assign pop    = (disp_q == StIdle) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      drop_q  <= newpkt & full;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= hdr_in;
  end

  // ---------------------------------------------------------------- dispatch FSM
  hdr_t       work_q, work_d;
  logic [3:0] win_q, win_d;
  logic [5:0] en_q, en_d;      // {kch, mni, qtu_fmb, nbr, reward, dst}
  logic [5:0] dec_vec;
  logic       match, is_dst;

  assign match  = (work_q.ch == chosenCH);
  assign is_dst = (work_q.dst == myNodeID);

  always_comb begin
    dec_vec    = '0;
    dec_vec[0] = is_dst;
    unique case (work_q.ptype)
      3'b000: begin dec_vec[4] = 1'b1; dec_vec[1] = 1'b1; end
      3'b001: dec_vec[4] = 1'b1;
      3'b010: begin
        dec_vec[5] = 1'b1;
        dec_vec[1] = (work_q.hops < WORD_WIDTH'(MAX_HOPS));
      end
      3'b011: begin
        dec_vec[3] = match;
        dec_vec[2] = match;
        dec_vec[1] = role;
      end
      3'b100: begin dec_vec[4] = is_dst; dec_vec[1] = role; end
      3'b101, 3'b110: begin
        dec_vec[3] = match;
        dec_vec[2] = match;
        dec_vec[1] = is_dst | iHaveData;
      end
      default: dec_vec[5:1] = '0;
    endcase
  end

  always_comb begin
    disp_d = disp_q;
    work_d = work_q;
    win_d  = win_q;
    en_d   = en_q;
    unique case (disp_q)
      StIdle: begin
        if (pop) begin
          work_d = mem_q[rd_ptr_q];
          disp_d = StDecode;
        end
      end
      StDecode: begin
        en_d   = dec_vec;
        win_d  = 4'(EN_CYCLES - 1);
        disp_d = StEnable;
      end
      StEnable: begin
        if (win_q == '0) begin
          en_d   = '0;
          disp_d = StIdle;
        end else begin
          win_d = win_q - 4'd1;
        end
      end
      default: disp_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= StIdle;
      work_q <= '0;
      win_q  <= '0;
      en_q   <= '0;
    end else begin
      disp_q <= disp_d;
      work_q <= work_d;
      win_q  <= win_d;
      en_q   <= en_d;
    end
  end

  // ---------------------------------------------------------------- CCA / TX FSM
  tx_e        tx_q, tx_d;
  logic [3:0] cca_q, cca_d;

  always_comb begin
    tx_d  = tx_q;
    cca_d = cca_q;
    unique case (tx_q)
      TxIdle: begin
        if (tx_req) begin
          tx_d  = TxCca;
          cca_d = '0;
        end
      end
      TxCca: begin
        // Dropping the request wins over a grant reached in the same cycle.
        if (!tx_req) begin
          tx_d  = TxIdle;
          cca_d = '0;
        end else if (channel_clear) begin
          if (cca_q + 4'd1 == 4'(CCA_CYCLES)) begin
            tx_d  = TxGrant;
            cca_d = '0;
          end else begin
            cca_d = cca_q + 4'd1;
          end
        end else begin
          cca_d = '0;
        end
      end
      TxGrant: begin
        if (tx_done) tx_d = TxIdle;
      end
      default: tx_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q  <= TxIdle;
      cca_q <= '0;
    end else begin
      tx_q  <= tx_d;
      cca_q <= cca_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign {en_KCH, en_reward, en_QTU_FMB, en_neighborTable, en_MNI, iAmDestination} =
         {en_q[5], en_q[1], en_q[3], en_q[2], en_q[4], en_q[0]};
  assign okToSend   = (tx_q == TxGrant);
  assign pkt_drop   = drop_q;
  assign fifo_count = count_q;
  assign busy       = (disp_q != StIdle);

endmodule

// File: tb/tb_pkt_dispatch_ctrl.sv
// Self-checking bench for pkt_dispatch_ctrl: directed scenarios plus random traffic,
// all compared each cycle against a schedule-level reference model.
module tb_pkt_dispatch_ctrl;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EN    = 3;
  localparam int unsigned MAXH  = 4;
  localparam int unsigned CCA   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         newpkt = 1'b0;
  logic [2:0]   fPacketType = '0;
  logic [W-1:0] fHopsFromCH = '0, fChosenCH = '0, destinationID = '0;
  logic [W-1:0] myNodeID = '0, chosenCH = '0;
  logic         role = 1'b0, iHaveData = 1'b0;
  logic         tx_req = 1'b0, tx_done = 1'b0, channel_clear = 1'b0;
  logic         en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination;
  logic         okToSend, pkt_drop, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  pkt_dispatch_ctrl #(
    .WORD_WIDTH(W), .FIFO_DEPTH(DEPTH), .EN_CYCLES(EN), .MAX_HOPS(MAXH), .CCA_CYCLES(CCA)
  ) dut (
    .clk(clk), .rst(rst), .newpkt(newpkt), .fPacketType(fPacketType),
    .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .destinationID(destinationID),
    .myNodeID(myNodeID), .chosenCH(chosenCH), .role(role), .iHaveData(iHaveData),
    .tx_req(tx_req), .tx_done(tx_done), .channel_clear(channel_clear),
    .en_KCH(en_KCH), .en_MNI(en_MNI), .en_QTU_FMB(en_QTU_FMB),
    .en_neighborTable(en_neighborTable), .en_reward(en_reward),
    .iAmDestination(iAmDestination), .okToSend(okToSend), .pkt_drop(pkt_drop),
    .fifo_count(fifo_count), .busy(busy)
  );

  typedef struct packed {
    logic [2:0]   t;
    logic [W-1:0] hops;
    logic [W-1:0] ch;
    logic [W-1:0] dst;
  } hdr_t;

  // Reference model: a header queue plus the edge numbers at which each window lives.
  hdr_t       q[$];
  int         edge_n, next_pop, pend_edge, win_lo, win_hi, busy_lo, busy_hi;
  bit         pend, exp_drop;
  hdr_t       pend_hdr;
  logic [5:0] win_vec;   // {kch, mni, qtu, nbr, reward, dst}
  int         tx_phase, clear_run;

  int n_checks = 0;
  int n_errors = 0;
  int drop_seen, busy_rises;
  bit prev_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] rules(input hdr_t h);
    bit m, d;
    logic [5:0] v;
    m = (h.ch == chosenCH);
    d = (h.dst == myNodeID);
    v = '0;
    case (h.t)
      3'd0: begin v[4] = 1; v[1] = 1; end
      3'd1: v[4] = 1;
      3'd2: begin v[5] = 1; v[1] = (h.hops < MAXH); end
      3'd3: begin v[3] = m; v[2] = m; v[1] = role; end
      3'd4: begin v[4] = d; v[1] = role; end
      3'd5, 3'd6: begin v[3] = m; v[2] = m; v[1] = d | iHaveData; end
      default: v = '0;
    endcase
    v[0] = d;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    pend      = 0;
    win_lo    = 1; win_hi  = 0;
    busy_lo   = 1; busy_hi = 0;
    exp_drop  = 0;
    next_pop  = 0;
    tx_phase  = 0;
    clear_run = 0;
  endtask

  task automatic model_edge();
    int   pre;
    hdr_t h;
    edge_n++;
    exp_drop = 0;
    if (pend && edge_n == pend_edge) begin
      win_vec = rules(pend_hdr);
      win_lo  = edge_n;
      win_hi  = edge_n + EN - 1;
      pend    = 0;
    end
    pre = q.size();
    if (pre != 0 && edge_n >= next_pop) begin
      pend_hdr  = q.pop_front();
      pend      = 1;
      pend_edge = edge_n + 1;
      busy_lo   = edge_n;
      busy_hi   = edge_n + EN;
      next_pop  = edge_n + EN + 2;
    end
    if (newpkt) begin
      if (pre == DEPTH) exp_drop = 1;
      else begin
        h = {fPacketType, fHopsFromCH, fChosenCH, destinationID};
        q.push_back(h);
      end
    end
    case (tx_phase)
      0: if (tx_req) begin tx_phase = 1; clear_run = 0; end
      1: begin
        if (!tx_req) tx_phase = 0;
        else if (channel_clear) begin
          clear_run++;
          if (clear_run == CCA) tx_phase = 2;
        end else clear_run = 0;
      end
      default: if (tx_done) tx_phase = 0;
    endcase
  endtask

  task automatic compare();
    logic [5:0] ev;
    ev = (edge_n >= win_lo && edge_n <= win_hi) ? win_vec : 6'd0;
    check_eq("enables", {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward,
                         iAmDestination}, ev);
    check_eq("busy", busy, (edge_n >= busy_lo && edge_n <= busy_hi));
    check_eq("pkt_drop", pkt_drop, exp_drop);
    check_eq("fifo_count", fifo_count, q.size());
    check_eq("okToSend", okToSend, tx_phase == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (pkt_drop) drop_seen++;
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_hdr(input logic [2:0] t, input logic [W-1:0] h, input logic [W-1:0] c,
                          input logic [W-1:0] d);
    newpkt = 1; fPacketType = t; fHopsFromCH = h; fChosenCH = c; destinationID = d;
    tick();
    newpkt = 0;
  endtask

  // Called just after an active edge; pulses reset between edges.
  task automatic async_reset();
    newpkt = 0;
    #2 rst = 1;
    #1;
    model_reset();
    compare();
    prev_busy = busy;
    #1 rst = 0;
  endtask

  task automatic rand_inputs();
    newpkt        = ($urandom_range(0, 99) < 40);
    fPacketType   = 3'($urandom_range(0, 7));
    fHopsFromCH   = W'($urandom_range(0, 7));
    fChosenCH     = ($urandom_range(0, 1) != 0) ? 16'd5 : 16'd7;
    destinationID = W'($urandom_range(1, 2));
    myNodeID      = W'($urandom_range(1, 2));
    chosenCH      = ($urandom_range(0, 1) != 0) ? 16'd5 : 16'd7;
    role          = 1'($urandom_range(0, 1));
    iHaveData     = 1'($urandom_range(0, 1));
    tx_req        = ($urandom_range(0, 99) < 85);
    channel_clear = ($urandom_range(0, 99) < 80);
    tx_done       = ($urandom_range(0, 99) < 15);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit pat [6] = '{1, 1, 0, 1, 1, 1};
    edge_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    check_eq("rst_count", fifo_count, 0);
    #3 rst = 0;
    prev_busy = 0;

    // Single HB: enables two edges after the push edge, held EN cycles.
    myNodeID = 16'd1; chosenCH = 16'd5; role = 0; iHaveData = 0;
    push_hdr(3'd0, 16'd0, 16'd0, 16'd2);
    tick();
    tick();
    check_eq("hb_mni", en_MNI, 1);
    check_eq("hb_reward", en_reward, 1);
    check_eq("hb_others", {en_KCH, en_QTU_FMB, en_neighborTable}, 0);
    idle_ticks(EN);
    check_eq("hb_closed", en_MNI, 0);
    idle_ticks(3);

    // MR gating on chosen-CH match and role.
    chosenCH = 16'd5; role = 1;
    push_hdr(3'd3, 16'd0, 16'd5, 16'd2);
    tick(); tick();
    check_eq("mr_match", {en_QTU_FMB, en_neighborTable, en_reward}, 3'b111);
    idle_ticks(EN + 2);
    chosenCH = 16'd7; role = 0;
    push_hdr(3'd3, 16'd0, 16'd5, 16'd2);
    tick(); tick();
    check_eq("mr_nomatch", {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward,
                            iAmDestination}, 0);
    idle_ticks(EN + 2);

    // INV hop-count boundary.
    push_hdr(3'd2, 16'd3, 16'd0, 16'd2);
    tick(); tick();
    check_eq("inv_h3", {en_KCH, en_reward}, 2'b11);
    idle_ticks(EN + 2);
    push_hdr(3'd2, 16'd4, 16'd0, 16'd2);
    tick(); tick();
    check_eq("inv_h4", {en_KCH, en_reward}, 2'b10);
    idle_ticks(EN + 2);

    // Overflow: six back-to-back pushes, five accepted.
    drop_seen = 0; busy_rises = 0;
    for (int i = 0; i < 6; i++) push_hdr(3'(i), 16'(i), 16'd5, 16'(i % 2 + 1));
    check_eq("ovf_count", fifo_count, DEPTH);
    idle_ticks(35);
    check_eq("ovf_drops", drop_seen, 1);
    check_eq("ovf_windows", busy_rises, 5);

    // CCA with an interrupted run of clear cycles.
    tx_req = 1; channel_clear = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      channel_clear = pat[i];
      tick();
      check_eq("cca_grant", okToSend, (i == 5));
    end
    tx_done = 1; channel_clear = 0;
    tick();
    check_eq("cca_done", okToSend, 0);
    tx_done = 0; tx_req = 0;
    idle_ticks(2);

    // Reset asserted in the middle of a DATA window.
    myNodeID = 16'd1; chosenCH = 16'd5;
    push_hdr(3'd5, 16'd0, 16'd5, 16'd1);
    push_hdr(3'd0, 16'd0, 16'd5, 16'd1);
    tick();
    check_eq("mw_window", {en_QTU_FMB, iAmDestination}, 2'b11);
    async_reset();
    check_eq("mw_cleared", {en_QTU_FMB, en_neighborTable, en_reward, iAmDestination}, 0);
    check_eq("mw_count", fifo_count, 0);
    busy_rises = 0;
    idle_ticks(12);
    check_eq("mw_nowin", busy_rises, 0);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      tick();
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
